// File: rtl/ser_irq_status.sv
// Serial IRQST/SKSTAT latch stage behind the POKEY serial core.
// Optional break detector: define SER_BREAK_DETECT_EN.
module ser_irq_status #(
  parameter logic [15:0] BREAK_LEN = 16'd2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic [7:0] Dw,
  input  logic       AddrIrqenW,
  input  logic       AddrSkresW,
  input  logic       setSdiCompl,
  input  logic       setFramerr,
  input  logic       setSdoCompl,
  input  logic       sdoFinish,
  input  logic       sdiBusy,
  input  logic       siDelay,
  output logic [2:0] irqStat,
  output logic [7:0] skStat,
  output logic       nIRQ,
  output logic       breakDet
);

  logic [5:3] irq_en;
  logic       pend5;
  logic       pend4;
  logic       fram_err;
  logic       overrun;
  logic       sdi_q;
  logic       fe_q;
  logic       sdo_q;
  logic       fin_q;
  logic       si_q;
  logic       busy_q;
  logic       n_irq_q;

  logic       ev_sdi;
  logic       ev_fe;
  logic       ev_sdo;
  logic [5:3] en_nx;
  logic [5:3] dis;
  logic       p5_nx;
  logic       p4_nx;
  logic       fe_nx;
  logic       ov_nx;
  logic       fin_nx;
  logic       n_irq_nx;

  // Enable bits are read before the write; a 0 written wins over a set.
  always_comb begin
    ev_sdi   = setSdiCompl & ~sdi_q;
    ev_fe    = setFramerr & ~fe_q;
    ev_sdo   = setSdoCompl & ~sdo_q;
    en_nx    = irq_en;
    dis      = 3'b000;
    if (AddrIrqenW) begin
      en_nx = Dw[5:3];
      dis   = ~Dw[5:3];
    end
    p5_nx    = (pend5 | (ev_sdi & irq_en[5])) & ~dis[5];
    p4_nx    = (pend4 | (ev_sdo & irq_en[4])) & ~dis[4];
    fe_nx    = (fram_err & ~AddrSkresW) | ev_fe;
    ov_nx    = (overrun & ~AddrSkresW) | (ev_sdi & pend5);
    fin_nx   = sdoFinish & en_nx[3];
    n_irq_nx = ~(p5_nx | p4_nx | fin_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en   <= 3'b000;
      pend5    <= 1'b0;
      pend4    <= 1'b0;
      fram_err <= 1'b0;
      overrun  <= 1'b0;
      sdi_q    <= 1'b0;
      fe_q     <= 1'b0;
      sdo_q    <= 1'b0;
      fin_q    <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      n_irq_q  <= 1'b1;
    end else if (enp) begin
      irq_en   <= en_nx;
      pend5    <= p5_nx;
      pend4    <= p4_nx;
      fram_err <= fe_nx;
      overrun  <= ov_nx;
      sdi_q    <= setSdiCompl;
      fe_q     <= setFramerr;
      sdo_q    <= setSdoCompl;
      fin_q    <= fin_nx;
      si_q     <= siDelay;
      busy_q   <= sdiBusy;
      n_irq_q  <= n_irq_nx;
    end
  end

  assign irqStat = ~{pend5, pend4, fin_q};
  assign nIRQ    = n_irq_q;
  assign skStat  = {~fram_err, 1'b1, ~overrun, ~si_q,
                    1'b1, 1'b1, ~busy_q, 1'b1};

`ifdef SER_BREAK_DETECT_EN
  logic [15:0] brk_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      brk_cnt <= 16'd0;
    end else if (enp) begin
      if (AddrSkresW || !siDelay)
        brk_cnt <= 16'd0;
      else if (brk_cnt != BREAK_LEN)
        brk_cnt <= brk_cnt + 16'd1;
    end
  end

  assign breakDet = (brk_cnt == BREAK_LEN);
`else
  logic unused_brk;
  assign unused_brk = ^BREAK_LEN;
  assign breakDet   = 1'b0;
`endif

  logic unused_dw;
  assign unused_dw = ^{Dw[7:6], Dw[2:0]};

endmodule

// File: tb/tb_ser_irq_status.sv
// Randomised + directed bench for ser_irq_status.
// Reference model tracks IRQST/SKSTAT rules at the register-bit level.
module tb_ser_irq_status;

  logic       clk = 1'b0;
  logic       reset;
  logic       enp;
  logic [7:0] Dw;
  logic       AddrIrqenW;
  logic       AddrSkresW;
  logic       setSdiCompl;
  logic       setFramerr;
  logic       setSdoCompl;
  logic       sdoFinish;
  logic       sdiBusy;
  logic       siDelay;
  logic [2:0] irqStat;
  logic [7:0] skStat;
  logic       nIRQ;
  logic       breakDet;

  int n_cmp = 0;
  int n_bad = 0;

  ser_irq_status #(.BREAK_LEN(16'd16)) dut (
    .clk(clk), .reset(reset), .enp(enp), .Dw(Dw),
    .AddrIrqenW(AddrIrqenW), .AddrSkresW(AddrSkresW),
    .setSdiCompl(setSdiCompl), .setFramerr(setFramerr),
    .setSdoCompl(setSdoCompl), .sdoFinish(sdoFinish),
    .sdiBusy(sdiBusy), .siDelay(siDelay),
    .irqStat(irqStat), .skStat(skStat),
    .nIRQ(nIRQ), .breakDet(breakDet)
  );

  always #5 clk = ~clk;

  // model state
  bit en5, en4, en3;
  bit m_p5, m_p4, m_fe, m_ov, m_fin, m_si, m_busy;
  bit last_sdi, last_fe, last_sdo;
  int m_cnt;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit es, ef, eo, old_p5;
    if (reset) begin
      {en5, en4, en3} = 3'b000;
      {m_p5, m_p4, m_fe, m_ov, m_fin, m_si, m_busy} = 7'b0;
      {last_sdi, last_fe, last_sdo} = 3'b000;
      m_cnt = 0;
      return;
    end
    if (!enp) return;
    es = setSdiCompl && !last_sdi;
    ef = setFramerr && !last_fe;
    eo = setSdoCompl && !last_sdo;
    old_p5 = m_p5;
    if (es && en5) m_p5 = 1;
    if (eo && en4) m_p4 = 1;
    if (AddrSkresW) begin m_fe = 0; m_ov = 0; end
    if (ef) m_fe = 1;
    if (es && old_p5) m_ov = 1;
    if (AddrIrqenW) begin
      en5 = Dw[5]; en4 = Dw[4]; en3 = Dw[3];
      if (!en5) m_p5 = 0;
      if (!en4) m_p4 = 0;
    end
    m_fin = sdoFinish && en3;
    m_si = siDelay;
    m_busy = sdiBusy;
    if (AddrSkresW || !siDelay) m_cnt = 0;
    else if (m_cnt < 16) m_cnt = m_cnt + 1;
    last_sdi = setSdiCompl;
    last_fe = setFramerr;
    last_sdo = setSdoCompl;
  endtask

  task automatic tick();
    logic [2:0] ei;
    logic [7:0] es;
    bit eb;
    @(posedge clk);
    model_edge();
    #1;
    ei = ~{m_p5, m_p4, m_fin};
    es = 8'hFF;
    es[7] = !m_fe;
    es[5] = !m_ov;
    es[4] = !m_si;
    es[1] = !m_busy;
`ifdef SER_BREAK_DETECT_EN
    eb = (m_cnt == 16);
`else
    eb = 0;
`endif
    check("irqStat", {5'b0, irqStat}, {5'b0, ei});
    check("skStat", skStat, es);
    check("nIRQ", {7'b0, nIRQ}, {7'b0, &ei});
    check("breakDet", {7'b0, breakDet}, {7'b0, eb});
  endtask

  task automatic irqen(input logic [7:0] d);
    Dw = d; AddrIrqenW = 1; tick(); AddrIrqenW = 0;
  endtask

  task automatic skres();
    AddrSkresW = 1; tick(); AddrSkresW = 0;
  endtask

  initial begin
    reset = 1; enp = 0; Dw = 0; AddrIrqenW = 0; AddrSkresW = 0;
    setSdiCompl = 0; setFramerr = 0; setSdoCompl = 0;
    sdoFinish = 0; sdiBusy = 0; siDelay = 0;
    tick(); tick();
    reset = 0; enp = 1;
    check("rst_irq", {5'b0, irqStat}, 8'h07);
    check("rst_sk", skStat, 8'hFF);
    check("rst_nirq", {7'b0, nIRQ}, 8'h01);
    check("rst_brk", {7'b0, breakDet}, 8'h00);

    irqen(8'h20);
    setSdiCompl = 1; tick();
    check("sdi_irq", {5'b0, irqStat}, 8'h03);
    check("sdi_nirq", {7'b0, nIRQ}, 8'h00);
    tick(); tick(); setSdiCompl = 0; tick();
    check("one_event", skStat, 8'hFF);
    setSdiCompl = 1; tick(); setSdiCompl = 0;
    check("overrun", {7'b0, skStat[5]}, 8'h00);
    tick();
    irqen(8'h00);
    check("dis_irq", {5'b0, irqStat}, 8'h07);
    check("dis_nirq", {7'b0, nIRQ}, 8'h01);
    check("ovr_hold", {7'b0, skStat[5]}, 8'h00);
    skres();
    check("skres", skStat, 8'hFF);

    setSdoCompl = 1; tick(); setSdoCompl = 0; tick();
    check("sdo_mask", {5'b0, irqStat}, 8'h07);
    irqen(8'h10);
    setSdoCompl = 1; tick(); setSdoCompl = 0; tick();
    check("sdo_irq", {5'b0, irqStat}, 8'h05);

    irqen(8'h00);
    setFramerr = 1; AddrSkresW = 1; tick();
    check("fe_win", {7'b0, skStat[7]}, 8'h00);
    setFramerr = 0; tick(); AddrSkresW = 0;
    check("fe_clr", {7'b0, skStat[7]}, 8'h01);

    irqen(8'h08);
    sdoFinish = 1; tick();
    check("fin_on", {7'b0, irqStat[0]}, 8'h00);
    sdoFinish = 0; enp = 0; tick();
    check("fin_hold", {7'b0, irqStat[0]}, 8'h00);
    enp = 1; tick();
    check("fin_off", {7'b0, irqStat[0]}, 8'h01);

    irqen(8'h00);
    siDelay = 1;
    for (int i = 0; i < 15; i++) tick();
    check("brk_15", {7'b0, breakDet}, 8'h00);
    tick();
`ifdef SER_BREAK_DETECT_EN
    check("brk_16", {7'b0, breakDet}, 8'h01);
`else
    check("brk_off", {7'b0, breakDet}, 8'h00);
`endif
    siDelay = 0; tick();
    check("brk_clr", {7'b0, breakDet}, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      enp = ($urandom_range(0, 4) != 0);
      Dw = 8'($urandom);
      AddrIrqenW = ($urandom_range(0, 9) == 0);
      AddrSkresW = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) setSdiCompl = ~setSdiCompl;
      if ($urandom_range(0, 3) == 0) setFramerr = ~setFramerr;
      if ($urandom_range(0, 2) == 0) setSdoCompl = ~setSdoCompl;
      if ($urandom_range(0, 3) == 0) sdoFinish = ~sdoFinish;
      sdiBusy = 1'($urandom);
      if ($urandom_range(0, 29) == 0) siDelay = ~siDelay;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
